// File: rtl/magic_pkg.sv
// magic_pkg: shared encodings, FSM states and instruction field offsets for the MAGIC NOR sequencer
package magic_pkg;
  typedef enum logic [1:0] {
    XB_INIT = 2'b00,
    XB_NOR1 = 2'b01,
    XB_NOR2 = 2'b10
  } xb_op_e;
  typedef enum logic [1:0] {
    OP_NOP  = 2'b00,
    OP_NOR1 = 2'b01,
    OP_NOR2 = 2'b10,
    OP_ILL  = 2'b11
  } op_e;
  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_INIT,
    S_EVAL,
    S_FIN
  } state_e;
  localparam int OP_W = 2;
  function automatic int instr_w(input int col_w);
    return OP_W + 3 * col_w;
  endfunction
  function automatic int op_lsb(input int col_w);
    return 3 * col_w;
  endfunction
  function automatic int a_lsb(input int col_w);
    return 2 * col_w;
  endfunction
  function automatic int b_lsb(input int col_w);
    return col_w;
  endfunction
endpackage

// File: rtl/magic_nor_seq_if.sv
// magic_nor_seq_if: host, program-memory and crossbar signals of the MAGIC NOR sequencer
interface magic_nor_seq_if #(
  parameter int COL_W = 8,
  parameter int PC_W  = 8
);
  localparam int INSTR_W = 2 + 3 * COL_W;
  logic               start;
  logic [PC_W-1:0]    prog_len;
  logic               abort;
  logic               busy;
  logic               done;
  logic               err;
  logic [PC_W-1:0]    gates_done;
  logic [PC_W-1:0]    imem_addr;
  logic [INSTR_W-1:0] imem_data;
  logic               xb_valid;
  logic               xb_ready;
  logic [1:0]         xb_op;
  logic [COL_W-1:0]   xb_a;
  logic [COL_W-1:0]   xb_b;
  logic [COL_W-1:0]   xb_dst;
  modport master (
    input  start, prog_len, abort, imem_data, xb_ready,
    output busy, done, err, gates_done, imem_addr, xb_valid, xb_op, xb_a, xb_b, xb_dst
  );
  modport slave (
    output start, prog_len, abort, imem_data, xb_ready,
    input  busy, done, err, gates_done, imem_addr, xb_valid, xb_op, xb_a, xb_b, xb_dst
  );
endinterface

// File: rtl/magic_instr_dec.sv
// magic_instr_dec: splits an instruction into op/operands, flags illegal ops and (MAGIC_HAZARD_CHECK_EN) operand hazards
module magic_instr_dec
  import magic_pkg::*;
#(
  parameter int COL_W = 8
) (
  input  logic [2+3*COL_W-1:0] i_data,
  output op_e                  o_op,
  output logic [COL_W-1:0]     o_a,
  output logic [COL_W-1:0]     o_b,
  output logic [COL_W-1:0]     o_dst,
  output logic                 o_nop,
  output logic                 o_illegal,
  output logic                 o_hazard
);
  localparam int OP_LSB = op_lsb(COL_W);
  localparam int A_LSB  = a_lsb(COL_W);
  localparam int B_LSB  = b_lsb(COL_W);
  logic [COL_W-1:0] w_b_raw;
  assign o_op      = op_e'(i_data[OP_LSB +: OP_W]);
  assign o_a       = i_data[A_LSB +: COL_W];
  assign w_b_raw   = i_data[B_LSB +: COL_W];
  assign o_dst     = i_data[COL_W-1:0];
  // NOR1 ignores the b field so the crossbar sees a clean zero there
  assign o_b       = o_op == OP_NOR2 ? w_b_raw : '0;
  assign o_nop     = o_op == OP_NOP;
  assign o_illegal = o_op == OP_ILL;
`ifdef MAGIC_HAZARD_CHECK_EN
  // INIT on a column that is also an input would wipe that operand before EVAL
  assign o_hazard  = (o_op == OP_NOR1 && o_dst == o_a) ||
                     (o_op == OP_NOR2 && (o_dst == o_a || o_dst == w_b_raw));
`else
  assign o_hazard  = 1'b0;
`endif
endmodule

// File: rtl/magic_nor_seq.sv
// magic_nor_seq: fetch/decode/INIT/EVAL sequencer running NOR netlists on a MAGIC crossbar row (hazard trap via MAGIC_HAZARD_CHECK_EN)
module magic_nor_seq
  import magic_pkg::*;
#(
  parameter int COL_W = 8,
  parameter int PC_W  = 8
) (
  input logic             clk,
  input logic             rst,
  magic_nor_seq_if.master bus
);
  state_e           r_state;
  state_e           w_next;
  logic [PC_W-1:0]  r_pc;
  logic [PC_W-1:0]  r_len;
  logic [PC_W-1:0]  r_gates;
  logic             r_err;
  logic             r_abort;
  op_e              r_op;
  logic [COL_W-1:0] r_a;
  logic [COL_W-1:0] r_b;
  logic [COL_W-1:0] r_dst;
  op_e              w_op;
  logic [COL_W-1:0] w_a;
  logic [COL_W-1:0] w_b;
  logic [COL_W-1:0] w_dst;
  logic             w_nop;
  logic             w_ill;
  logic             w_haz;
  logic             w_bad;
  logic             w_fire;
  logic             w_stop;
  logic             w_eval;
  magic_instr_dec #(.COL_W(COL_W)) u_dec (
    .i_data   (bus.imem_data),
    .o_op     (w_op),
    .o_a      (w_a),
    .o_b      (w_b),
    .o_dst    (w_dst),
    .o_nop    (w_nop),
    .o_illegal(w_ill),
    .o_hazard (w_haz)
  );
  assign w_bad          = w_ill | w_haz;
  assign w_fire         = bus.xb_valid & bus.xb_ready;
  // an abort seen during INIT/EVAL is remembered so a short pulse still ends the run
  assign w_stop         = (r_pc == r_len - PC_W'(1)) | bus.abort | r_abort;
  assign w_eval         = r_state == S_EVAL;
  assign bus.busy       = r_state != S_IDLE && r_state != S_FIN;
  assign bus.done       = r_state == S_FIN;
  assign bus.err        = r_err;
  assign bus.gates_done = r_gates;
  assign bus.imem_addr  = r_pc;
  assign bus.xb_valid   = r_state == S_INIT || w_eval;
  assign bus.xb_op      = w_eval ? 2'(r_op) : 2'(XB_INIT);
  assign bus.xb_a       = w_eval ? r_a : '0;
  assign bus.xb_b       = w_eval ? r_b : '0;
  assign bus.xb_dst     = bus.xb_valid ? r_dst : '0;
  // next-state: commands hold until their handshake, abort only acts at gate boundaries
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   w_next = bus.start ? (bus.prog_len == '0 ? S_FIN : S_FETCH) : S_IDLE;
      S_FETCH:  w_next = bus.abort ? S_FIN : S_DECODE;
      S_DECODE: w_next = (bus.abort || w_bad || (w_nop && w_stop)) ? S_FIN : w_nop ? S_FETCH : S_INIT;
      S_INIT:   w_next = w_fire ? S_EVAL : S_INIT;
      S_EVAL:   w_next = w_fire ? (w_stop ? S_FIN : S_FETCH) : S_EVAL;
      default:  w_next = S_IDLE;
    endcase
  end
  // state, program counter, instruction register and run status
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_pc    <= '0;
      r_len   <= '0;
      r_gates <= '0;
      r_err   <= 1'b0;
      r_abort <= 1'b0;
      r_op    <= OP_NOP;
      r_a     <= '0;
      r_b     <= '0;
      r_dst   <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == S_IDLE && bus.start) begin
        r_len   <= bus.prog_len;
        r_pc    <= '0;
        r_gates <= '0;
        r_err   <= 1'b0;
        r_abort <= 1'b0;
      end
      if (r_state == S_DECODE) begin
        r_op  <= w_op;
        r_a   <= w_a;
        r_b   <= w_b;
        r_dst <= w_dst;
        if (w_bad) r_err <= 1'b1;
      end
      if ((r_state == S_INIT || w_eval) && bus.abort) r_abort <= 1'b1;
      if (w_eval && w_fire) r_gates <= r_gates + PC_W'(1);
      if (r_state != S_IDLE && w_next == S_FETCH) r_pc <= r_pc + PC_W'(1);
    end
  end
endmodule
